// File: rtl/regfile_param_if.sv
// Register file access bundle: read/write addresses, write data, read enables, read data and ready.
// The master drives addresses and data; the slave returns registered read data and the ready flag.
interface regfile_param_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic              RegWrite;
    logic              re1;
    logic              re2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              ready;

    modport master (
        output WriteData, rs1, rs2, rd, RegWrite, re1, re2,
        input  ReadData1, ReadData2, ready
    );

    modport slave (
        input  WriteData, rs1, rs2, rd, RegWrite, re1, re2,
        output ReadData1, ReadData2, ready
    );
endinterface

// File: rtl/regfile_param.sv
// 2-read/1-write register file with post-reset init sweep; reads are 1-cycle registered, write-first bypass.
// No backpressure: ready stays low through reset and the DEPTH-cycle sweep, inputs are ignored meanwhile.
module regfile_param #(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG  = 1,
    parameter int INIT_MODE = 1
) (
    input  logic           clk,
    input  logic           reset,
    regfile_param_if.slave bus
);
    typedef enum logic [1:0] {RST, INIT, RUN} state_t;

    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              rdy;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_ok;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] init_val;
    logic [DATA_W-1:0] rv1;
    logic [DATA_W-1:0] rv2;

    always_comb begin
        wr_ok    = bus.RegWrite && ({1'b0, bus.rd} < DEPTH_X) &&
                   !((ZERO_REG != 0) && (bus.rd == '0));
        init_val = (INIT_MODE == 1) ? DATA_W'(idx) : '0;
        wr_en    = reset && ((state == INIT) || ((state == RUN) && wr_ok));
        wr_addr  = (state == INIT) ? idx : bus.rd;
        wr_data  = (state == INIT) ? init_val : bus.WriteData;

        // Write-first: a performed write to the same address wins over the array
        if (wr_ok && (bus.rs1 == bus.rd))
            rv1 = bus.WriteData;
        else if (({1'b0, bus.rs1} >= DEPTH_X) || ((ZERO_REG != 0) && (bus.rs1 == '0)))
            rv1 = '0;
        else
            rv1 = mem[bus.rs1];

        if (wr_ok && (bus.rs2 == bus.rd))
            rv2 = bus.WriteData;
        else if (({1'b0, bus.rs2} >= DEPTH_X) || ((ZERO_REG != 0) && (bus.rs2 == '0)))
            rv2 = '0;
        else
            rv2 = mem[bus.rs2];
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= RST;
            idx    <= '0;
            rdata1 <= '0;
            rdata2 <= '0;
            rdy    <= 1'b0;
        end else begin
            case (state)
                RST: begin
                    state  <= INIT;
                    idx    <= '0;
                    rdata1 <= '0;
                    rdata2 <= '0;
                    rdy    <= 1'b0;
                end
                INIT: begin
                    rdata1 <= '0;
                    rdata2 <= '0;
                    if (idx == LAST) begin
                        state <= RUN;
                        idx   <= '0;
                        rdy   <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RUN: begin
                    if (bus.re1)
                        rdata1 <= rv1;
                    if (bus.re2)
                        rdata2 <= rv2;
                end
                default: begin
                    state <= RST;
                    rdy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ReadData1 = rdata1;
    assign bus.ReadData2 = rdata2;
    assign bus.ready     = rdy;
endmodule

// File: tb/tb_regfile_param.sv
// Three register-file instances (default, ZERO_REG=0, DEPTH=24/INIT_MODE=0) driven in lockstep.
// Expected read data comes from a bench-side model pushed to a scoreboard queue each cycle.
module tb_regfile_param;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] WriteData;
    logic [4:0]  rs1, rs2, rd;
    logic        RegWrite, re1, re2;

    always #5 clk = ~clk;

    regfile_param_if #(.DATA_W(64), .ADDR_W(5)) ia ();
    regfile_param_if #(.DATA_W(64), .ADDR_W(5)) ib ();
    regfile_param_if #(.DATA_W(64), .ADDR_W(5)) ic ();

    assign ia.WriteData = WriteData; assign ib.WriteData = WriteData; assign ic.WriteData = WriteData;
    assign ia.rs1 = rs1; assign ib.rs1 = rs1; assign ic.rs1 = rs1;
    assign ia.rs2 = rs2; assign ib.rs2 = rs2; assign ic.rs2 = rs2;
    assign ia.rd  = rd;  assign ib.rd  = rd;  assign ic.rd  = rd;
    assign ia.RegWrite = RegWrite; assign ib.RegWrite = RegWrite; assign ic.RegWrite = RegWrite;
    assign ia.re1 = re1; assign ib.re1 = re1; assign ic.re1 = re1;
    assign ia.re2 = re2; assign ib.re2 = re2; assign ic.re2 = re2;

    regfile_param #(.DATA_W(64), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .INIT_MODE(1))
        dut_a (.clk(clk), .reset(reset), .bus(ia));
    regfile_param #(.DATA_W(64), .DEPTH(32), .ADDR_W(5), .ZERO_REG(0), .INIT_MODE(1))
        dut_b (.clk(clk), .reset(reset), .bus(ib));
    regfile_param #(.DATA_W(64), .DEPTH(24), .ADDR_W(5), .ZERO_REG(1), .INIT_MODE(0))
        dut_c (.clk(clk), .reset(reset), .bus(ic));

    logic [63:0] rd1 [3];
    logic [63:0] rd2 [3];
    logic        rdy [3];
    always_comb begin
        rd1[0] = ia.ReadData1; rd1[1] = ib.ReadData1; rd1[2] = ic.ReadData1;
        rd2[0] = ia.ReadData2; rd2[1] = ib.ReadData2; rd2[2] = ic.ReadData2;
        rdy[0] = ia.ready;     rdy[1] = ib.ready;     rdy[2] = ic.ready;
    end

    typedef struct packed {
        logic [2:0][63:0] r1;
        logic [2:0][63:0] r2;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          nvec = 0;
    int          nerr = 0;
    logic [63:0] mdl [3][32];
    logic [63:0] po1 [3];
    logic [63:0] po2 [3];
    int          dep   [3] = '{32, 32, 24};
    int          zero  [3] = '{1, 0, 1};
    int          imode [3] = '{1, 1, 0};

    task automatic set_idle();
        RegWrite = 1'b0; re1 = 1'b0; re2 = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; WriteData = '0;
    endtask

    task automatic model_init();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 32; i++)
                mdl[k][i] = (imode[k] == 1 && i < dep[k]) ? 64'(i) : 64'd0;
            po1[k] = '0;
            po2[k] = '0;
        end
    endtask

    // Predict this cycle's read data for all instances, queue it, then clock the DUTs
    task automatic cycle();
        exp_t        n;
        logic        we;
        logic [63:0] v1, v2;
        for (int k = 0; k < 3; k++) begin
            we = RegWrite && (int'(rd) < dep[k]) && !(zero[k] == 1 && rd == 5'd0);
            v1 = po1[k];
            v2 = po2[k];
            if (re1) begin
                if (we && rs1 == rd) v1 = WriteData;
                else if (int'(rs1) >= dep[k] || (zero[k] == 1 && rs1 == 5'd0)) v1 = '0;
                else v1 = mdl[k][rs1];
            end
            if (re2) begin
                if (we && rs2 == rd) v2 = WriteData;
                else if (int'(rs2) >= dep[k] || (zero[k] == 1 && rs2 == 5'd0)) v2 = '0;
                else v2 = mdl[k][rs2];
            end
            if (we) mdl[k][rd] = WriteData;
            po1[k] = v1;
            po2[k] = v2;
            n.r1[k] = v1;
            n.r2[k] = v2;
        end
        q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic exp_r;
        reset = 1'b0;
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            nvec += 3;
            if (rdy[k] !== 1'b0) begin nerr++; $display("FAIL reset_ready[%0d] got %b want 0", k, rdy[k]); end
            if (rd1[k] !== 64'd0) begin nerr++; $display("FAIL reset_rd1[%0d] got %h want 0", k, rd1[k]); end
            if (rd2[k] !== 64'd0) begin nerr++; $display("FAIL reset_rd2[%0d] got %h want 0", k, rd2[k]); end
        end
        // Writes and reads are offered during the sweep and must be ignored
        reset = 1'b1;
        RegWrite = 1'b1; rd = 5'd5; WriteData = '1;
        re1 = 1'b1; rs1 = 5'd5; re2 = 1'b1; rs2 = 5'd7;
        for (int n = 1; n <= 33; n++) begin
            if (n == 26) begin RegWrite = 1'b0; re1 = 1'b0; re2 = 1'b0; end
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                exp_r = (n >= dep[k] + 1);
                nvec += 2;
                if (rdy[k] !== exp_r) begin nerr++; $display("FAIL init_ready[%0d] edge %0d got %b want %b", k, n, rdy[k], exp_r); end
                if (rd1[k] !== 64'd0) begin nerr++; $display("FAIL init_rd1[%0d] edge %0d got %h want 0", k, n, rd1[k]); end
            end
        end
        set_idle();
        model_init();
    endtask

    task automatic test_init_read();
        re1 = 1'b1; rs1 = 5'd7; re2 = 1'b1; rs2 = 5'd31;
        cycle();
        e = q.pop_front();
        for (int k = 0; k < 3; k++) begin
            nvec += 2;
            if (rd1[k] !== e.r1[k]) begin nerr++; $display("FAIL init_read rd1[%0d] got %h want %h", k, rd1[k], e.r1[k]); end
            if (rd2[k] !== e.r2[k]) begin nerr++; $display("FAIL init_read rd2[%0d] got %h want %h", k, rd2[k], e.r2[k]); end
        end
        nvec += 2;
        if (rd1[0] !== 64'd7)  begin nerr++; $display("FAIL init_r7 got %h want 7", rd1[0]); end
        if (rd2[0] !== 64'd31) begin nerr++; $display("FAIL init_r31 got %h want 31", rd2[0]); end
        rs1 = 5'd5; rs2 = 5'd0;
        cycle();
        e = q.pop_front();
        for (int k = 0; k < 3; k++) begin
            nvec += 2;
            if (rd1[k] !== e.r1[k]) begin nerr++; $display("FAIL init_ignwr rd1[%0d] got %h want %h", k, rd1[k], e.r1[k]); end
            if (rd2[k] !== e.r2[k]) begin nerr++; $display("FAIL init_ignwr rd2[%0d] got %h want %h", k, rd2[k], e.r2[k]); end
        end
        nvec++;
        if (rd1[0] !== 64'd5) begin nerr++; $display("FAIL init_r5 got %h want 5", rd1[0]); end
        set_idle();
    endtask

    task automatic test_write_bypass();
        RegWrite = 1'b1; rd = 5'd5; WriteData = 64'hDEAD_BEEF; re1 = 1'b1; rs1 = 5'd5;
        cycle();
        e = q.pop_front();
        for (int k = 0; k < 3; k++) begin
            nvec++;
            if (rd1[k] !== e.r1[k]) begin nerr++; $display("FAIL bypass rd1[%0d] got %h want %h", k, rd1[k], e.r1[k]); end
        end
        nvec++;
        if (rd1[0] !== 64'hDEAD_BEEF) begin nerr++; $display("FAIL bypass_const got %h want deadbeef", rd1[0]); end
        RegWrite = 1'b0; re1 = 1'b0; re2 = 1'b1; rs2 = 5'd5;
        cycle();
        e = q.pop_front();
        for (int k = 0; k < 3; k++) begin
            nvec++;
            if (rd2[k] !== e.r2[k]) begin nerr++; $display("FAIL wr_then_rd rd2[%0d] got %h want %h", k, rd2[k], e.r2[k]); end
        end
        nvec++;
        if (rd2[0] !== 64'hDEAD_BEEF) begin nerr++; $display("FAIL wr_then_rd_const got %h want deadbeef", rd2[0]); end
        set_idle();
    endtask

    task automatic test_zero_reg();
        for (int c = 0; c < 2; c++) begin
            RegWrite = (c == 0); rd = 5'd0; WriteData = 64'hFF; re1 = 1'b1; rs1 = 5'd0;
            cycle();
            e = q.pop_front();
            for (int k = 0; k < 3; k++) begin
                nvec++;
                if (rd1[k] !== e.r1[k]) begin nerr++; $display("FAIL zero_reg c%0d rd1[%0d] got %h want %h", c, k, rd1[k], e.r1[k]); end
            end
            nvec += 2;
            if (rd1[0] !== 64'd0)  begin nerr++; $display("FAIL zero_hard c%0d got %h want 0", c, rd1[0]); end
            if (rd1[1] !== 64'hFF) begin nerr++; $display("FAIL zero_soft c%0d got %h want ff", c, rd1[1]); end
        end
        set_idle();
    endtask

    task automatic test_re_hold();
        re1 = 1'b1; rs1 = 5'd3;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) begin re1 = 1'b0; rs1 = 5'd9; end
            if (c == 5) re1 = 1'b1;
            cycle();
            e = q.pop_front();
            for (int k = 0; k < 3; k++) begin
                nvec++;
                if (rd1[k] !== e.r1[k]) begin nerr++; $display("FAIL re_hold c%0d rd1[%0d] got %h want %h", c, k, rd1[k], e.r1[k]); end
            end
            nvec++;
            if (rd1[0] !== ((c == 5) ? 64'd9 : 64'd3)) begin nerr++; $display("FAIL re_hold_const c%0d got %h", c, rd1[0]); end
        end
        set_idle();
    endtask

    task automatic test_out_of_range();
        RegWrite = 1'b1; rd = 5'd30; WriteData = 64'h55; re1 = 1'b1; rs1 = 5'd30;
        re2 = 1'b1; rs2 = 5'd24;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) RegWrite = 1'b0;
            if (c == 2) rs1 = 5'd23;
            cycle();
            e = q.pop_front();
            for (int k = 0; k < 3; k++) begin
                nvec += 2;
                if (rd1[k] !== e.r1[k]) begin nerr++; $display("FAIL range c%0d rd1[%0d] got %h want %h", c, k, rd1[k], e.r1[k]); end
                if (rd2[k] !== e.r2[k]) begin nerr++; $display("FAIL range c%0d rd2[%0d] got %h want %h", c, k, rd2[k], e.r2[k]); end
            end
            nvec++;
            if (rd1[2] !== 64'd0) begin nerr++; $display("FAIL range_c_const c%0d got %h want 0", c, rd1[2]); end
        end
        set_idle();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            RegWrite  = 1'($urandom_range(0, 1));
            rd        = 5'($urandom_range(0, 31));
            WriteData = {$urandom, $urandom};
            re1       = ($urandom_range(0, 3) != 0);
            re2       = ($urandom_range(0, 3) != 0);
            rs1       = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2       = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            cycle();
            e = q.pop_front();
            for (int k = 0; k < 3; k++) begin
                nvec += 2;
                if (rd1[k] !== e.r1[k]) begin nerr++; $display("FAIL b2b c%0d rd1[%0d] got %h want %h", c, k, rd1[k], e.r1[k]); end
                if (rd2[k] !== e.r2[k]) begin nerr++; $display("FAIL b2b c%0d rd2[%0d] got %h want %h", c, k, rd2[k], e.r2[k]); end
            end
        end
        set_idle();
    endtask

    task automatic test_reset_mid_init();
        logic exp_r;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        nvec++;
        if (rdy[0] !== 1'b0) begin nerr++; $display("FAIL mid_init_pre got %b want 0", rdy[0]); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            nvec++;
            if (rdy[k] !== 1'b0) begin nerr++; $display("FAIL mid_init_rst[%0d] got %b want 0", k, rdy[k]); end
        end
        reset = 1'b1;
        for (int n = 1; n <= 33; n++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                exp_r = (n >= dep[k] + 1);
                nvec++;
                if (rdy[k] !== exp_r) begin nerr++; $display("FAIL mid_init_ready[%0d] edge %0d got %b want %b", k, n, rdy[k], exp_r); end
            end
        end
        model_init();
        re1 = 1'b1; rs1 = 5'd20; re2 = 1'b1; rs2 = 5'd23;
        cycle();
        e = q.pop_front();
        for (int k = 0; k < 3; k++) begin
            nvec += 2;
            if (rd1[k] !== e.r1[k]) begin nerr++; $display("FAIL mid_init_rd rd1[%0d] got %h want %h", k, rd1[k], e.r1[k]); end
            if (rd2[k] !== e.r2[k]) begin nerr++; $display("FAIL mid_init_rd rd2[%0d] got %h want %h", k, rd2[k], e.r2[k]); end
        end
        nvec++;
        if (rd1[0] !== 64'd20) begin nerr++; $display("FAIL mid_init_r20 got %h want 20", rd1[0]); end
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        set_idle();
        test_reset();
        test_init_read();
        test_write_bypass();
        test_zero_reg();
        test_re_hold();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_init();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
